rx_sample_reader: RTL and testbench
===================================

# rx_sample_reader

Consumer end of the receiver sample interface. On each `rx_avail_A` strobe it drives the `rd_i`/`rd_q` selects to read out one complex sample as 16-bit words, and writes those words into a local FIFO. The FIFO drains on a valid/ready stream that marks frame boundaries for the downstream sample buffer / CPU transfer logic. It sits in the `adc_clk` domain directly after the receiver's final decimator.

## Interface
Parameters:
- `DEPTH`, 1024, FIFO depth in 16-bit words; power of 2, ≥ 8
- `SAMPS_PER_FRAME`, 16, complex samples per frame; ≥ 1

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - `adc_clk`  in  1  sole clock
  - `reset_n`  in  1  reset, sampled on `adc_clk`
- Control and receiver side:
  - `enable`  in  1  level; low = ignore new strobes
  - `rx_avail_A`  in  1  one-cycle strobe, new sample ready
  - `rx_dout_A`  in  16  receiver word, combinational from `rd_i`/`rd_q`
  - `rd_i`  out  1  select I word (registered)
  - `rd_q`  out  1  select Q word (registered)
- Output stream:
  - `out_data`  out  16  FIFO head word
  - `out_valid`  out  1  head word valid
  - `out_ready`  in  1  downstream accepts when `out_valid && out_ready`
  - `out_last`  out  1  head word is final word of a frame
- Status:
  - `fifo_count`  out  clog2(DEPTH)+1  words stored
  - `ovfl_cnt`  out  16  dropped samples, saturating at 16'hFFFF

## Operation
- Word set per sample: `WPS` = 2 (I, Q), or 3 with the packed-MSB word (see Configuration).
- FSM states: `IDLE`, `RD_I`, `RD_Q`, `RD_P` (`RD_P` only when the macro is defined).
- `IDLE`: when `rx_avail_A && enable`:
  - If free space ≥ `WPS`, go to `RD_I`.
  - Otherwise drop the sample, increment `ovfl_cnt`, and stay in `IDLE`.
  - Free space = DEPTH − `fifo_count`, evaluated in the same cycle and including any simultaneous pop.
- `RD_I`: `rd_i`=1 and `rd_q`=0; write `rx_dout_A` into the FIFO; next state is `RD_Q`.
- `RD_Q`: `rd_i`=0 and `rd_q`=1; write `rx_dout_A`; next state is `RD_P` if the macro is defined, else `IDLE`.
- `RD_P`: `rd_i`=0 and `rd_q`=0; write `rx_dout_A` (I[MSB-:8], Q[MSB-:8]); next state is `IDLE`.
- `rx_avail_A` in any non-`IDLE` state: sample dropped and `ovfl_cnt` incremented; the in-progress sample is unaffected.
- `enable` falling mid-sample: the current sample completes. Strobes with `enable`=0 are ignored and not counted.
- Frame tagging:
  - A sample counter (0..SAMPS_PER_FRAME−1) advances once per fully written sample and wraps to 0.
  - The last word of the sample written while the counter is SAMPS_PER_FRAME−1 is stored with a tag bit; `out_last` presents that tag.
  - Dropped samples do not advance the counter.
- FIFO behaviour:
  - First-word fall-through; push and pop in the same cycle are legal.
  - `fifo_count` is never > DEPTH and never underflows.
  - The admission check guarantees a push never lands on a full FIFO.

## Timing
- Strobe at cycle N (IDLE, room available):
  - `rd_i`=1 in N+1, `rd_q`=1 in N+2, packed write in N+3 when the macro is defined.
  - FSM is back in `IDLE` at N+3 (or N+4 with the macro); a strobe in that cycle is accepted.
- Latency: a word written in cycle k has `out_valid`=1 and `out_data` valid in k+1 if the FIFO was empty.
- Handshake: `out_data`, `out_last` and `out_valid` hold until accepted. Back-to-back pops at one word per cycle.
- Reset (`reset_n`=0 at a clock edge), including mid-sample: at the next edge state = `IDLE`; `rd_i`=`rd_q`=0; FIFO emptied (`out_valid`=0, `out_last`=0, `fifo_count`=0); `ovfl_cnt`=0; frame counter=0. A partial sample is discarded.
- `out_data` is don't-care while `out_valid`=0.

## Configuration
- `RX_PACKED_MSB_EN` defined:
  - `WPS`=3; `RD_P` is present and each sample appends the packed 8+8 MSB word after Q.
  - The admission check requires 3 free words.
- Undefined: `RD_P` is removed, `WPS`=2, and the FSM returns to `IDLE` from `RD_Q`.

## Test plan
- Single sample, macro off: with `rx_dout_A` modelled as I=16'h1234 and Q=16'hABCD per selects, one strobe → words 1234, ABCD appear; `rd_i` high exactly in N+1, `rd_q` exactly in N+2; `fifo_count`=2.
- Frame marking, SAMPS_PER_FRAME=4, `out_ready`=1: 8 samples → `out_last` high only on words 8 and 16 (macro off), or on words 12 and 24 (macro on).
- Overflow, DEPTH=8, macro off, `out_ready`=0: 5 strobes → `fifo_count`=8 and `ovfl_cnt`=1. Raising `out_ready` with a simultaneous strobe when `fifo_count`=7 → sample accepted.
- Strobe while busy: strobes at N and N+1 → second sample dropped and `ovfl_cnt`=1. Strobes at N and N+3 (macro off) → both accepted.
- Reset mid-sample: `reset_n`=0 during `RD_Q` with 5 words stored → next cycle `fifo_count`=0, `out_valid`=0, `rd_q`=0, `ovfl_cnt`=0. A following strobe produces a fresh frame with the sample counter at 0.

Source files
------------

// File: rtl/rx_sample_reader_if.sv
// Receiver-select and output-stream signals of rx_sample_reader.
// The master side is the reader; the slave side is the receiver plus downstream consumer.
interface rx_sample_reader_if;
  logic        enable;
  logic        rx_avail_A;
  logic [15:0] rx_dout_A;
  logic        rd_i;
  logic        rd_q;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    input  enable, rx_avail_A, rx_dout_A, out_ready,
    output rd_i, rd_q, out_data, out_valid, out_last
  );

  modport slave (
    output enable, rx_avail_A, rx_dout_A, out_ready,
    input  rd_i, rd_q, out_data, out_valid, out_last
  );
endinterface

// File: rtl/rx_sample_reader.sv
// Reads one complex sample per rx_avail_A strobe into a first-word-fall-through FIFO
// drained as a framed valid/ready stream. Optional packed-MSB word: RX_PACKED_MSB_EN.
module rx_sample_reader #(
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned SAMPS_PER_FRAME = 16
) (
  input  logic                    adc_clk,
  input  logic                    reset_n,
  rx_sample_reader_if.master      bus,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [15:0]             ovfl_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (SAMPS_PER_FRAME > 1) ? $clog2(SAMPS_PER_FRAME) : 1;

`ifdef RX_PACKED_MSB_EN
  localparam int unsigned WPS = 3;
  typedef enum logic [1:0] {IDLE, RD_I, RD_Q, RD_P} state_t;
`else
  localparam int unsigned WPS = 2;
  typedef enum logic [1:0] {IDLE, RD_I, RD_Q} state_t;
`endif

  state_t          state;
  state_t          state_n;
  logic            push;
  logic            push_last;
  logic            pop;
  logic            ovfl_inc;
  logic            room;
  logic            frame_end;
  logic [CW-1:0]   free_words;
  logic [16:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [SW-1:0]   samp_cnt;

  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_data  = mem[rd_ptr][15:0];
  assign bus.out_last  = bus.out_valid && mem[rd_ptr][16];

  assign pop        = bus.out_valid && bus.out_ready;
  // A pop in the admission cycle frees a slot before the first word lands.
  assign free_words = CW'(DEPTH) - fifo_count + CW'(pop);
  assign room       = (free_words >= CW'(WPS));
  assign frame_end  = (samp_cnt == SW'(SAMPS_PER_FRAME - 1));

  always_comb begin
    state_n   = state;
    push      = 1'b0;
    push_last = 1'b0;
    ovfl_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_avail_A && bus.enable) begin
          if (room) state_n = RD_I;
          else      ovfl_inc = 1'b1;
        end
      end
      RD_I: begin
        push    = 1'b1;
        state_n = RD_Q;
      end
      RD_Q: begin
        push = 1'b1;
`ifdef RX_PACKED_MSB_EN
        state_n = RD_P;
`else
        push_last = 1'b1;
        state_n   = IDLE;
`endif
      end
`ifdef RX_PACKED_MSB_EN
      RD_P: begin
        push      = 1'b1;
        push_last = 1'b1;
        state_n   = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
    if (state != IDLE && bus.rx_avail_A && bus.enable) ovfl_inc = 1'b1;
  end

  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      bus.rd_i <= 1'b0;
      bus.rd_q <= 1'b0;
    end else begin
      state    <= state_n;
      bus.rd_i <= (state_n == RD_I);
      bus.rd_q <= (state_n == RD_Q);
    end
  end

  always_ff @(posedge adc_clk) begin
    if (push) mem[wr_ptr] <= {push_last && frame_end, bus.rx_dout_A};
  end

  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      samp_cnt   <= '0;
      ovfl_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push_last) samp_cnt <= frame_end ? '0 : samp_cnt + 1'b1;
      if (ovfl_inc && ovfl_cnt != '1) ovfl_cnt <= ovfl_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_sample_reader.sv
// Self-checking bench for rx_sample_reader: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based sample model.
module tb_rx_sample_reader;
  localparam int DEPTH = 8;
  localparam int SPF   = 4;
`ifdef RX_PACKED_MSB_EN
  localparam int WPS = 3;
`else
  localparam int WPS = 2;
`endif

  logic        adc_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  fifo_count;
  logic [15:0] ovfl_cnt;
  logic [15:0] i_val;
  logic [15:0] q_val;
  bit          rand_dout = 1'b0;

  rx_sample_reader_if bus();

  // Receiver model: word chosen combinationally by the selects; packed MSBs otherwise.
  assign bus.rx_dout_A = bus.rd_i ? i_val : (bus.rd_q ? q_val : {i_val[15:8], q_val[15:8]});

  rx_sample_reader #(.DEPTH(DEPTH), .SAMPS_PER_FRAME(SPF)) dut (
    .adc_clk    (adc_clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .fifo_count (fifo_count),
    .ovfl_cnt   (ovfl_cnt)
  );

  always #5 adc_clk = ~adc_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected FIFO contents, drop counter, frame position, and the
  // cycle index at which the in-flight sample was admitted.
  logic [16:0] mq[$];
  int          m_ovfl = 0;
  int          m_samp = 0;
  int          acc    = -100;
  int          cyc    = 0;
  bit          live   = 1'b0;
  int          k;
  bit          m_pop;
  bit          accept;
  logic [15:0] w;

  always @(posedge adc_clk) begin
    if (!reset_n) begin
      mq.delete();
      m_ovfl = 0;
      m_samp = 0;
      acc    = -100;
      live   = 1'b1;
    end else begin
      k      = cyc - acc;
      m_pop  = (mq.size() > 0) && bus.out_ready;
      accept = 1'b0;
      if (bus.rx_avail_A && bus.enable) begin
        if (k >= 1 && k <= WPS)                         m_ovfl = (m_ovfl < 65535) ? m_ovfl + 1 : m_ovfl;
        else if (DEPTH - mq.size() + int'(m_pop) >= WPS) accept = 1'b1;
        else                                            m_ovfl = (m_ovfl < 65535) ? m_ovfl + 1 : m_ovfl;
      end
      if (m_pop) void'(mq.pop_front());
      if (k >= 1 && k <= WPS) begin
        w = (k == 1) ? i_val : ((k == 2) ? q_val : {i_val[15:8], q_val[15:8]});
        mq.push_back({(k == WPS) && (m_samp == SPF - 1), w});
        if (k == WPS) m_samp = (m_samp + 1) % SPF;
      end
      if (accept) acc = cyc;
    end
    cyc++;
  end

  always @(negedge adc_clk) begin
    if (live) begin
      chk("fifo_count", int'(fifo_count), mq.size());
      chk("out_valid", int'(bus.out_valid), int'(mq.size() > 0));
      chk("out_last", int'(bus.out_last), (mq.size() > 0) ? int'(mq[0][16]) : 0);
      if (mq.size() > 0) chk("out_data", int'(bus.out_data), int'(mq[0][15:0]));
      chk("ovfl_cnt", int'(ovfl_cnt), m_ovfl);
      chk("rd_i", int'(bus.rd_i), int'(cyc - acc == 1));
      chk("rd_q", int'(bus.rd_q), int'(cyc - acc == 2));
    end
  end

  // Frame-marking monitor: index (1-based) of each accepted word carrying out_last.
  bit mon_on = 1'b0;
  int widx   = 0;
  int lasts[$];
  always @(negedge adc_clk) begin
    if (mon_on && bus.out_valid && bus.out_ready) begin
      widx++;
      if (bus.out_last) lasts.push_back(widx);
    end
  end

  task automatic tick();
    @(posedge adc_clk);
    #1;
    if (rand_dout) begin
      i_val = 16'($urandom);
      q_val = 16'($urandom);
    end
  endtask

  task automatic sample_gap(input int gap);
    bus.rx_avail_A = 1'b1;
    tick();
    bus.rx_avail_A = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    bus.enable     = 1'b1;
    bus.rx_avail_A = 1'b0;
    bus.out_ready  = 1'b0;
    i_val = 16'h1234;
    q_val = 16'hABCD;
    repeat (3) tick();
    @(negedge adc_clk);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_ovfl", int'(ovfl_cnt), 0);
    reset_n = 1'b1;
    tick();

    // Single sample, pinned I/Q words and select timing.
    bus.rx_avail_A = 1'b1;
    tick();
    bus.rx_avail_A = 1'b0;
    @(negedge adc_clk);
    chk("one_rd_i_n1", int'(bus.rd_i), 1);
    chk("one_rd_q_n1", int'(bus.rd_q), 0);
    tick();
    @(negedge adc_clk);
    chk("one_rd_i_n2", int'(bus.rd_i), 0);
    chk("one_rd_q_n2", int'(bus.rd_q), 1);
    chk("one_count_n2", int'(fifo_count), 1);
    tick();
    @(negedge adc_clk);
    chk("one_rd_q_n3", int'(bus.rd_q), 0);
    chk("one_count", int'(fifo_count), 2);
    chk("one_word_i", int'(bus.out_data), 16'h1234);
    bus.out_ready = 1'b1;
    tick();
    @(negedge adc_clk);
    chk("one_word_q", int'(bus.out_data), 16'hABCD);
    tick();
    @(negedge adc_clk);
    chk("one_drained", int'(bus.out_valid), 0);
    bus.out_ready = 1'b0;

    // Overflow with a stalled consumer, then admission helped by a same-cycle pop.
    repeat (5) sample_gap(2);
    @(negedge adc_clk);
    chk("ovf_count_full", int'(fifo_count), 8);
    chk("ovf_cnt_one", int'(ovfl_cnt), 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    @(negedge adc_clk);
    chk("ovf_count_7", int'(fifo_count), 7);
    bus.out_ready  = 1'b1;
    bus.rx_avail_A = 1'b1;
    tick();
    bus.out_ready  = 1'b0;
    bus.rx_avail_A = 1'b0;
    repeat (2) tick();
    @(negedge adc_clk);
    chk("ovf_pop_admit", int'(fifo_count), 8);
    chk("ovf_cnt_kept", int'(ovfl_cnt), 1);

    // Strobes while busy.
    bus.out_ready = 1'b1;
    repeat (12) tick();
    bus.out_ready  = 1'b0;
    bus.rx_avail_A = 1'b1;
    repeat (2) tick();
    bus.rx_avail_A = 1'b0;
    repeat (3) tick();
    @(negedge adc_clk);
    chk("busy_drop", int'(ovfl_cnt), 2);
    sample_gap(2);
    sample_gap(4);
    @(negedge adc_clk);
`ifdef RX_PACKED_MSB_EN
    chk("busy_n3", int'(ovfl_cnt), 3);
`else
    chk("busy_n3", int'(ovfl_cnt), 2);
    chk("busy_n3_words", int'(fifo_count), 6);
`endif

    // Reset mid-sample with five words stored.
    bus.out_ready = 1'b1;
    repeat (12) tick();
    bus.out_ready = 1'b0;
    sample_gap(WPS + 1);
    sample_gap(WPS + 1);
    bus.rx_avail_A = 1'b1;
    tick();
    bus.rx_avail_A = 1'b0;
    tick();
    @(negedge adc_clk);
`ifndef RX_PACKED_MSB_EN
    chk("mid_count", int'(fifo_count), 5);
`endif
    chk("mid_rd_q", int'(bus.rd_q), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge adc_clk);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_rd_q", int'(bus.rd_q), 0);
    chk("mid_rst_ovfl", int'(ovfl_cnt), 0);

    // Fresh frames after reset, consumer always ready.
    rand_dout     = 1'b1;
    bus.out_ready = 1'b1;
    mon_on        = 1'b1;
    repeat (8) sample_gap(WPS);
    repeat (6) tick();
    mon_on = 1'b0;
    chk("frame_words", widx, 8 * WPS);
    chk("frame_nlast", lasts.size(), 2);
    if (lasts.size() >= 2) begin
      chk("frame_last1", lasts[0], SPF * WPS);
      chk("frame_last2", lasts[1], 2 * SPF * WPS);
    end

    // Randomized traffic: strobes, enable, backpressure and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      bus.rx_avail_A = ($urandom_range(2) == 0);
      bus.enable     = ($urandom_range(9) != 0);
      bus.out_ready  = ($urandom_range(3) < ((c < 2000) ? 1 : 3));
      reset_n        = ($urandom_range(499) != 0);
      tick();
    end
    reset_n        = 1'b1;
    bus.rx_avail_A = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
